// File: rtl/free_block_pool.sv
// rtl/free_block_pool.sv - circular pool of erased block IDs, self-filled after reset
// Optional duplicate-push detection is enabled by defining FREE_POOL_DUP_CHECK_EN.
module free_block_pool #(
    parameter int BLK_W  = 8,
    parameter int DEPTH  = 16,
    parameter int LOW_WM = 4,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             push_en,
    input  logic [BLK_W-1:0] push_blk,
    input  logic             pop_en,
    output logic [BLK_W-1:0] pop_blk,
    output logic             pop_valid,
    output logic [BLK_W-1:0] recover_blk,
    output logic             fifo_recover_en,
    output logic             ready,
    output logic [CNT_W-1:0] count,
    output logic             low_water,
    output logic             overflow_err,
    output logic             underflow_err,
    output logic             dup_err
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] LOW_WM_C = CNT_W'(LOW_WM);

    typedef enum logic {INIT, RUN} state_t;

    state_t           state;
    logic [BLK_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] init_idx;
    logic [BLK_W-1:0] head_blk;
    logic             running;
    logic             pop_ok;
    logic             room;
    logic             dup_hit;
    logic             push_ok;

    assign head_blk = mem[rd_ptr];
    assign running  = (state == RUN);
    assign pop_ok   = running && pop_en && (count != '0);
    // A full pool still takes a push when a pop frees the head slot on the same edge.
    assign room     = (count != DEPTH_C) || pop_ok;
    assign push_ok  = running && push_en && !dup_hit && room;

`ifdef FREE_POOL_DUP_CHECK_EN
    logic [DEPTH-1:0] bitmap;
    logic [DEPTH-1:0] bitmap_nxt;
    logic             in_range;
    logic             self_pop;
    logic             dup_err_q;

    assign in_range = 32'(push_blk) < DEPTH;
    // Popping the same ID this cycle frees its membership before the push is judged.
    assign self_pop = pop_ok && (head_blk == push_blk);
    assign dup_hit  = !in_range || (bitmap[push_blk[PTR_W-1:0]] && !self_pop);
    assign dup_err  = dup_err_q;

    always_comb begin
        bitmap_nxt = bitmap;
        if (state == INIT) begin
            bitmap_nxt[init_idx] = 1'b1;
        end else begin
            if (pop_ok)
                bitmap_nxt[head_blk[PTR_W-1:0]] = 1'b0;
            if (push_ok)
                bitmap_nxt[push_blk[PTR_W-1:0]] = 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            bitmap    <= '0;
            dup_err_q <= 1'b0;
        end else begin
            bitmap <= bitmap_nxt;
            if (running && push_en && dup_hit)
                dup_err_q <= 1'b1;
        end
    end
`else
    assign dup_hit = 1'b0;
    assign dup_err = 1'b0;
`endif

    // Storage is not reset; INIT rewrites every slot before it becomes visible.
    always_ff @(posedge CLK) begin
        if (state == INIT)
            mem[init_idx] <= BLK_W'(init_idx);
        else if (push_ok)
            mem[wr_ptr] <= push_blk;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state           <= INIT;
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            init_idx        <= '0;
            count           <= '0;
            ready           <= 1'b0;
            recover_blk     <= '0;
            fifo_recover_en <= 1'b0;
            overflow_err    <= 1'b0;
            underflow_err   <= 1'b0;
        end else begin
            case (state)
                INIT: begin
                    fifo_recover_en <= 1'b0;
                    wr_ptr          <= wr_ptr + 1'b1;
                    init_idx        <= init_idx + 1'b1;
                    count           <= count + 1'b1;
                    if (init_idx == PTR_W'(DEPTH - 1)) begin
                        state <= RUN;
                        ready <= 1'b1;
                    end
                end
                RUN: begin
                    fifo_recover_en <= push_ok;
                    if (push_ok) begin
                        recover_blk <= push_blk;
                        wr_ptr      <= wr_ptr + 1'b1;
                    end
                    if (pop_ok)
                        rd_ptr <= rd_ptr + 1'b1;
                    count <= count + CNT_W'(push_ok) - CNT_W'(pop_ok);
                    if (push_en && !dup_hit && !room)
                        overflow_err <= 1'b1;
                    if (pop_en && (count == '0))
                        underflow_err <= 1'b1;
                end
                default: state <= INIT;
            endcase
        end
    end

    assign pop_blk   = ready ? head_blk : '0;
    assign pop_valid = ready && (count != '0);
    assign low_water = ready && (count <= LOW_WM_C);

endmodule

// File: tb/tb_free_block_pool.sv
// tb/tb_free_block_pool.sv - scoreboard bench for free_block_pool against a queue model
module tb_free_block_pool;
`ifdef FREE_POOL_DUP_CHECK_EN
    localparam bit DUP = 1'b1;
`else
    localparam bit DUP = 1'b0;
`endif

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       push_en = 1'b0;
    logic [7:0] push_blk = '0;
    logic       pop_en = 1'b0;
    logic [7:0] pop_blk;
    logic       pop_valid;
    logic [7:0] recover_blk;
    logic       fifo_recover_en;
    logic       ready;
    logic [4:0] count;
    logic       low_water;
    logic       overflow_err;
    logic       underflow_err;
    logic       dup_err;

    free_block_pool dut (
        .CLK(CLK), .RST(RST),
        .push_en(push_en), .push_blk(push_blk), .pop_en(pop_en),
        .pop_blk(pop_blk), .pop_valid(pop_valid),
        .recover_blk(recover_blk), .fifo_recover_en(fifo_recover_en),
        .ready(ready), .count(count), .low_water(low_water),
        .overflow_err(overflow_err), .underflow_err(underflow_err), .dup_err(dup_err)
    );

    always #5 CLK = ~CLK;

    int tests = 0;
    int fails = 0;

    int q[$];
    int exp_ack[$];
    int exp_pop[$];
    bit m_ovf, m_unf, m_dup;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    // Monitor: consumes expectations whenever the DUT shows an ack or a consumed head.
    always @(negedge CLK) begin
        if (fifo_recover_en) begin
            if (exp_ack.size() == 0) begin
                tests++; fails++;
                $display("FAIL unexpected_ack: got recover_blk %0d expected no ack", recover_blk);
            end else begin
                chk("recover_blk", recover_blk, exp_ack.pop_front());
            end
        end
        if (pop_en && pop_valid) begin
            if (exp_pop.size() == 0) begin
                tests++; fails++;
                $display("FAIL unexpected_pop: got pop_blk %0d expected no pop", pop_blk);
            end else begin
                chk("pop_blk_seq", pop_blk, exp_pop.pop_front());
            end
        end
    end

    function automatic bit in_pool(int b);
        foreach (q[i]) if (q[i] == b) return 1'b1;
        return 1'b0;
    endfunction

    task automatic check_state();
        chk("ready", ready, 1);
        chk("count", count, q.size());
        chk("pop_valid", pop_valid, q.size() != 0);
        chk("low_water", low_water, q.size() <= 4);
        chk("overflow_err", overflow_err, m_ovf);
        chk("underflow_err", underflow_err, m_unf);
        chk("dup_err", dup_err, m_dup);
        if (q.size() != 0) chk("pop_blk_head", pop_blk, q[0]);
    endtask

    task automatic step(input bit pu, input int b, input bit po);
        bit pop_acc, push_acc, is_dup;
        push_en = pu; push_blk = 8'(b); pop_en = po;
        pop_acc = po && (q.size() > 0);
        is_dup  = DUP && ((b >= 16) || (in_pool(b) && !(pop_acc && q[0] == b)));
        push_acc = pu && !is_dup && ((q.size() < 16) || pop_acc);
        if (pu && is_dup) m_dup = 1'b1;
        else if (pu && !push_acc) m_ovf = 1'b1;
        if (po && !pop_acc) m_unf = 1'b1;
        if (pop_acc) exp_pop.push_back(q.pop_front());
        if (push_acc) begin
            q.push_back(b);
            exp_ack.push_back(b);
        end
        @(posedge CLK); #1;
        push_en = 1'b0; pop_en = 1'b0;
        check_state();
    endtask

    task automatic do_init();
        RST = 1'b1;
        q.delete(); exp_ack.delete(); exp_pop.delete();
        m_ovf = 0; m_unf = 0; m_dup = 0;
        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            @(posedge CLK); #1;
            chk("init_ready", ready, i == 16);
            if (i < 16) chk("init_low_water", low_water, 0);
        end
        for (int i = 0; i < 16; i++) q.push_back(i);
        check_state();
    endtask

    initial begin
        #1;
        chk("rst_ready", ready, 0);
        chk("rst_count", count, 0);
        do_init();

        // Drain to the low-water mark, then one push lifts it.
        for (int i = 0; i < 12; i++) step(0, 0, 1);
        step(1, 3, 0);

        // Fill to full, overflow, then simultaneous push+pop at full.
        for (int i = 0; i < 12; i++) if (i != 3) step(1, i, 0);
        step(1, 7, 0);
        step(1, q[0], 1);

        // Drain to empty, push+pop on empty, then 40 wrapping pairs.
        while (q.size() > 0) step(0, 0, 1);
        step(1, 5, 1);
        for (int i = 0; i < 40; i++) step(1, (6 + i) % 16, 1);

        // Build count 9, then reset mid-run.
        for (int i = 0; i < 8; i++) step(1, i, 0);
        chk("pre_rst_count", count, 9);
        RST = 1'b1; #1;
        chk("mid_rst_ready", ready, 0);
        chk("mid_rst_count", count, 0);
        chk("mid_rst_pop_valid", pop_valid, 0);
        chk("mid_rst_pop_blk", pop_blk, 0);
        chk("mid_rst_ack", fifo_recover_en, 0);
        chk("mid_rst_recover_blk", recover_blk, 0);
        chk("mid_rst_errs", {overflow_err, underflow_err, dup_err}, 0);
        do_init();
        for (int i = 0; i < 16; i++) step(0, 0, 1);

        // Duplicate handling on a freshly initialised pool.
        do_init();
        step(0, 0, 1);
        step(0, 0, 1);
        step(1, 0, 0);
        step(1, 0, 0);
        step(1, 200, 0);

        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 1), $urandom_range(0, DUP ? 17 : 15), ($urandom_range(0, 2) == 0));

        step(0, 0, 0);
        #5;
        chk("ack_queue_drained", exp_ack.size(), 0);
        chk("pop_queue_drained", exp_pop.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
